// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants, the word type and a helper for pointer
//                widths, used by the FIFO read-side controller.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Data width of the team's enqueue/dequeue FIFO.
    localparam int FIFO_DW = 32;

    typedef logic [FIFO_DW-1:0] word_t;

    // Pointer width for a power-of-two circular buffer; never below one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_drain_rd_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buf
//  Description : Parameterised circular buffer with push/pop and occupancy.
//                The head entry is presented combinationally from storage.
//  Revision    : 1.0  initial release
// ============================================================================
module skid_buf
    import fifo_pkg::*;
#(
    parameter int DW    = FIFO_DW,
    parameter int DEPTH = 2,
    localparam int PW   = ptr_w(DEPTH),
    localparam int OW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [OW-1:0] occ
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [OW-1:0] r_occ;

    // Storage is not cleared by reset; a write is suppressed while in reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign head = r_mem[r_rd_ptr];
    assign occ  = r_occ;

endmodule : skid_buf
`default_nettype wire

// File: rtl/fifo_drain_rd.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain_rd
//  Description : Read-side controller for the 32-bit FIFO. Dequeues only when
//                buffer space is guaranteed, absorbs the one-cycle read
//                latency in a skid buffer, and re-presents words on a
//                valid/ready stream with a word counter and XOR checksum.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_drain_rd
    import fifo_pkg::*;
#(
    parameter int DW        = FIFO_DW,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_deq,
    input  logic [DW-1:0]    fifo_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic [DW-1:0]    checksum,
    output logic             busy
);

    localparam int OW = ptr_w(BUF_DEPTH) + 1;

    logic             r_inflight;
    logic [CNT_W-1:0] r_word_cnt;
    logic [DW-1:0]    r_checksum;
    logic [OW-1:0]    w_occ;
    logic             w_pop;
    logic [OW:0]      w_level;
    logic             w_deq;

    // Words committed to the buffer once everything in flight lands and the
    // current pop leaves; one extra bit so occ + inflight cannot overflow.
    assign m_valid = (w_occ != '0);
    assign w_pop   = m_valid && m_ready;
    assign w_level = {1'b0, w_occ} + {{OW{1'b0}}, r_inflight} - {{OW{1'b0}}, w_pop};
    assign w_deq   = !rst && !fifo_empty && (w_level < (OW+1)'(BUF_DEPTH));

    assign fifo_deq = w_deq;
    assign busy     = m_valid || r_inflight;
    assign word_cnt = r_word_cnt;
    assign checksum = r_checksum;

    // Track the FIFO read latency: data arrives the cycle after a dequeue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_deq;
        end
    end

    // Delivered-word counter and checksum advance on each accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_checksum <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
            r_checksum <= r_checksum ^ m_data;
        end
    end

    skid_buf #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (fifo_rdata),
        .pop       (w_pop),
        .head      (m_data),
        .occ       (w_occ)
    );

endmodule : fifo_drain_rd
`default_nettype wire

// File: doc/fifo_drain_rd.md
# fifo_drain_rd

Read-side controller for the team's 32-bit enqueue/dequeue FIFO. It issues `fifo_deq` whenever the FIFO is non-empty and downstream space is guaranteed, and absorbs the FIFO's one-cycle read latency in a small skid buffer. Words are re-presented on a valid/ready stream, with a delivered-word counter and an XOR checksum for bring-up. It sits between the FIFO's dequeue port and any consumer that can apply backpressure.

## Interface
- `DW`, 32, data width; must match the FIFO.
- `BUF_DEPTH`, 2, skid-buffer entries; at least 2, power of two.
- `CNT_W`, 16, width of the delivered-word counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_deq`  out  1  dequeue strobe to the FIFO.
- `fifo_rdata`  in  DW  FIFO read data, valid the cycle after `fifo_deq`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  DW  output word (buffer head).
- `word_cnt`  out  CNT_W  words delivered; wraps modulo 2^CNT_W.
- `checksum`  out  DW  XOR of all delivered words.
- `busy`  out  1  a word is buffered or in flight.

## Operation
- **State:**
  - `inflight`: 1 bit; registered copy of `fifo_deq`.
  - Circular buffer with `wr_ptr`, `rd_ptr` and `occ` (0..BUF_DEPTH).
  - `word_cnt` and `checksum` registers.
- **Pop:** `pop = m_valid && m_ready`.
- **Dequeue rule (combinational):** `fifo_deq = !fifo_empty && (occ + inflight - pop) < BUF_DEPTH`.
  - This rule guarantees the buffer never overflows.
  - `fifo_deq` is never asserted while `fifo_empty` is high.
- **Capture:** when `inflight` = 1, write `fifo_rdata` at `wr_ptr` and increment `wr_ptr`.
- **Output:**
  - `m_valid = (occ != 0)`.
  - `m_data = buf[rd_ptr]`.
  - `m_data` must hold stable while `m_valid && !m_ready`.
- **On pop:**
  - Increment `rd_ptr`.
  - `word_cnt += 1`.
  - `checksum ^= m_data`.
- **Occupancy:** capture and pop in the same cycle leave `occ` unchanged. The pointers wrap modulo BUF_DEPTH.
- **Status:** `busy = (occ != 0) || inflight`.
- **Reset:**
  - Clears `occ`, both pointers, `inflight`, `word_cnt` and `checksum`.
  - Outputs after reset: `fifo_deq` = 0 for that cycle, `m_valid` = 0, `m_data` = don't-care (the buffer is not cleared), `word_cnt` = 0, `checksum` = 0, `busy` = 0.
- **Reset mid-operation:** a word in flight at reset is dropped, not captured. The FIFO-side loss is accepted; the FIFO is reset alongside this block.
- **Contract violation:** `fifo_empty` rising while `inflight` = 1 does not cancel the capture.

## Timing
- **Latency:** `fifo_deq` in cycle N → captured at the N+1 edge → `m_valid` high in cycle N+2.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, one word per cycle in steady state.
- **Combinational paths:**
  - `fifo_deq` depends combinationally on `fifo_empty` and `m_ready`.
  - No combinational path from `fifo_rdata` to any output.
- **Backpressure:** with `m_ready` low, at most BUF_DEPTH words are buffered. `fifo_deq` stays low until a pop frees space; dequeue resumes in the same cycle as that pop.
- **Counter:** `word_cnt` and `checksum` update on the edge that ends the pop cycle.

## Structure
- Shared package `fifo_pkg`:
  - `DW` default.
  - `typedef logic [DW-1:0] word_t`.
  - A `BUF_DEPTH`-derived pointer width function.
- One sub-module, `skid_buf`: a parameterised circular buffer with push/pop/occ. The top level holds the dequeue rule, `inflight`, the counter and the checksum.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `fifo_empty`=0 → `fifo_deq`=0, `m_valid`=0, `word_cnt`=0, `checksum`=0 throughout.
- **Streaming:**
  - Stimulus: preload the FIFO with 10 words `32'h1..32'hA`, `m_ready`=1.
  - Response: `fifo_deq` high for 10 consecutive cycles; `m_data` = 1..A on 10 consecutive cycles, starting 2 cycles after the first `fifo_deq`.
  - End state: `word_cnt`=10, `checksum`=`32'hB`.
- **Backpressure:**
  - Stimulus: `m_ready`=0 with 5 words queued.
  - Response: exactly 2 `fifo_deq` pulses, then held low; `m_data` holds word 1.
  - Release `m_ready` → the remaining 3 are delivered in order, with no loss or duplication.
- **Empty gaps:** alternate `fifo_empty` every cycle → `fifo_deq` only when `fifo_empty`=0; the output order matches the input order.
- **Reset mid-stream:**
  - Stimulus: assert `rst` in the cycle after a `fifo_deq`.
  - Response: the next cycle shows `m_valid`=0, `busy`=0, `word_cnt`=0; the in-flight word never appears.
- **Counter wrap:** `CNT_W`=4, deliver 17 words → `word_cnt`=1.
